// File: rtl/zeroheti_irq_pkg.sv
// Shared types and defaults for the zeroheti interrupt arbiter.
package zeroheti_irq_pkg;

  localparam int NumIrqsDefault = 32;
  localparam int PrioWDefault   = 3;

  // Byte layout of a per-source configuration word (write and read).
  typedef struct packed {
    logic [2:0] prio;
    logic [1:0] rsvd;
    logic       ip;
    logic       trig;
    logic       ie;
  } irq_cfg_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OFFER = 2'd1,
    GAP   = 2'd2
  } irq_state_e;

endpackage

// File: rtl/zeroheti_irq_prio_tree.sv
// Combinational max-priority reduction tree. Ineligible entries enter the
// tree as priority 0; on equal priority the left (lower index) child wins.
module zeroheti_irq_prio_tree #(
  parameter  int NumIrqs = 32,
  parameter  int PrioW   = 3,
  localparam int IdW     = $clog2(NumIrqs)
) (
  input  logic [NumIrqs-1:0]            eligible,
  input  logic [NumIrqs-1:0][PrioW-1:0] prio,
  output logic                          found,
  output logic [IdW-1:0]                id,
  output logic [PrioW-1:0]              max_prio
);

  localparam int NumLeaves = 1 << IdW;
  localparam int NumNodes  = 2 * NumLeaves - 1;

  // Heap-ordered node storage: node n has children 2n+1 (left) and 2n+2.
  logic [PrioW-1:0] node_prio [NumNodes];
  logic [IdW-1:0]   node_id   [NumNodes];

  // Fill leaves, then reduce bottom-up toward the root.
  always_comb begin
    for (int n = 0; n < NumNodes; n++) begin
      node_prio[n] = '0;
      node_id[n]   = '0;
    end
    for (int k = 0; k < NumIrqs; k++) begin
      node_prio[NumLeaves-1+k] = eligible[k] ? prio[k] : '0;
      node_id[NumLeaves-1+k]   = IdW'(k);
    end
    for (int n = NumLeaves - 2; n >= 0; n--) begin
      if (node_prio[2*n+2] > node_prio[2*n+1]) begin
        node_prio[n] = node_prio[2*n+2];
        node_id[n]   = node_id[2*n+2];
      end else begin
        node_prio[n] = node_prio[2*n+1];
        node_id[n]   = node_id[2*n+1];
      end
    end
  end

  assign found    = (node_prio[0] != '0);
  assign id       = node_id[0];
  assign max_prio = node_prio[0];

endmodule

// File: rtl/zeroheti_irq_arbiter.sv
// Interrupt arbiter in front of zeroheti_core: pending/enable per source,
// priority selection against the core threshold, valid/ready offer.
// Optional build macro ZEROHETI_IRQ_EDGE_EN adds per-source edge triggering;
// without it every source is level-triggered and trig reads as 0.
//
// state | meaning
// IDLE  | waiting for an eligible source above threshold
// OFFER | id/prio held on the outputs until the core claims
// GAP   | one quiet cycle so the core can raise its threshold
module zeroheti_irq_arbiter
  import zeroheti_irq_pkg::*;
#(
  parameter  int NumIrqs = NumIrqsDefault,
  parameter  int PrioW   = PrioWDefault,
  localparam int IdW     = $clog2(NumIrqs)
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [NumIrqs-1:0] irq_i,
  input  logic               cfg_we_i,
  input  logic               cfg_re_i,
  input  logic [IdW-1:0]     cfg_addr_i,
  input  logic [7:0]         cfg_wdata_i,
  output logic [7:0]         cfg_rdata_o,
  input  logic [PrioW-1:0]   threshold_i,
  output logic               irq_valid_o,
  output logic [IdW-1:0]     irq_id_o,
  output logic [PrioW-1:0]   irq_prio_o,
  input  logic               irq_ready_i
);

  irq_state_e state_q, state_d;

  logic [NumIrqs-1:0]            ie_q;
  logic [NumIrqs-1:0]            ip_q, ip_d;
  logic [NumIrqs-1:0][PrioW-1:0] prio_q;
  logic [NumIrqs-1:0]            eligible;

  irq_cfg_t wcfg, rcfg;
  logic     addr_ok, wr_en, claim, load_offer, offer_ok;
  logic     win_found;
  logic [IdW-1:0]   win_id;
  logic [PrioW-1:0] win_prio;
  logic     unused_cfg_bits;

  assign wcfg    = irq_cfg_t'(cfg_wdata_i);
  assign addr_ok = (32'(cfg_addr_i) < NumIrqs);
  assign wr_en   = cfg_we_i && addr_ok;
  assign unused_cfg_bits = ^{wcfg.rsvd, wcfg.ip, wcfg.trig};

`ifdef ZEROHETI_IRQ_EDGE_EN
  logic [NumIrqs-1:0] trig_q, trig_next, irq_prev_q;
  logic [NumIrqs-1:0] wr_sel, claim_sel, edge_evt, ip_edge;

  assign wr_sel    = wr_en ? (NumIrqs'(1) << cfg_addr_i) : '0;
  assign claim_sel = claim ? (NumIrqs'(1) << irq_id_o) : '0;
  assign edge_evt  = irq_i & ~irq_prev_q;
  // The trig value after this cycle's write decides how ip evolves.
  assign trig_next = (trig_q & ~wr_sel) | (wr_sel & {NumIrqs{wcfg.trig}});
  // Edge sources: write/claim may clear, a same-cycle edge always wins.
  assign ip_edge   = (((ip_q & ~wr_sel) | (wr_sel & {NumIrqs{wcfg.ip}})) & ~claim_sel)
                     | edge_evt;
  assign ip_d      = (trig_next & ip_edge) | (~trig_next & irq_i);

  // Trigger mode and previous-sample register for the edge detector.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      trig_q     <= '0;
      irq_prev_q <= '0;
    end else begin
      trig_q     <= trig_next;
      irq_prev_q <= irq_i;
    end
  end
`else
  assign ip_d = irq_i;
`endif

  // Enable and priority fields written from the config port.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ie_q   <= '0;
      prio_q <= '0;
    end else if (wr_en) begin
      ie_q[cfg_addr_i]   <= wcfg.ie;
      prio_q[cfg_addr_i] <= PrioW'(wcfg.prio);
    end
  end

  // Pending bits.
  always_ff @(posedge clk_i) begin
    if (rst_i) ip_q <= '0;
    else       ip_q <= ip_d;
  end

  // Assemble the read word for the addressed source.
  always_comb begin
    rcfg = '0;
    if (addr_ok) begin
      rcfg.prio = 3'(prio_q[cfg_addr_i]);
      rcfg.ip   = ip_q[cfg_addr_i];
      rcfg.ie   = ie_q[cfg_addr_i];
`ifdef ZEROHETI_IRQ_EDGE_EN
      rcfg.trig = trig_q[cfg_addr_i];
`endif
    end
  end

  // Read data register, updated only on a read strobe.
  always_ff @(posedge clk_i) begin
    if (rst_i)         cfg_rdata_o <= '0;
    else if (cfg_re_i) cfg_rdata_o <= rcfg;
  end

  assign eligible = ip_q & ie_q;

  zeroheti_irq_prio_tree #(
    .NumIrqs (NumIrqs),
    .PrioW   (PrioW)
  ) u_prio_tree (
    .eligible (eligible),
    .prio     (prio_q),
    .found    (win_found),
    .id       (win_id),
    .max_prio (win_prio)
  );

  assign offer_ok = win_found && (win_prio > threshold_i);

  // FSM state register.
  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // FSM next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (offer_ok) state_d = OFFER;
      OFFER:   if (claim)    state_d = GAP;
      GAP:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs and handshake qualifiers.
  always_comb begin
    irq_valid_o = (state_q == OFFER);
    claim       = (state_q == OFFER) && irq_ready_i;
    load_offer  = (state_q == IDLE) && offer_ok;
  end

  // Offered id/prio, frozen from IDLE->OFFER until the next offer.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      irq_id_o   <= '0;
      irq_prio_o <= '0;
    end else if (load_offer) begin
      irq_id_o   <= win_id;
      irq_prio_o <= win_prio;
    end
  end

endmodule

// File: tb/tb_zeroheti_irq_arbiter.sv
// Directed self-checking bench for zeroheti_irq_arbiter.
module tb_zeroheti_irq_arbiter;

  localparam int NumIrqs = 32;
  localparam int PrioW   = 3;
  localparam int IdW     = 5;

`ifdef ZEROHETI_IRQ_EDGE_EN
  localparam bit EdgeEn = 1'b1;
`else
  localparam bit EdgeEn = 1'b0;
`endif

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic [NumIrqs-1:0] irq = '0;
  logic               cfg_we = 1'b0;
  logic               cfg_re = 1'b0;
  logic [IdW-1:0]     cfg_addr = '0;
  logic [7:0]         cfg_wdata = '0;
  logic [7:0]         cfg_rdata;
  logic [PrioW-1:0]   threshold = '0;
  logic               irq_valid;
  logic [IdW-1:0]     irq_id;
  logic [PrioW-1:0]   irq_prio;
  logic               irq_ready = 1'b0;

  int errors = 0;
  int checks = 0;
  logic [7:0] rd;

  zeroheti_irq_arbiter #(.NumIrqs(NumIrqs), .PrioW(PrioW)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .irq_i       (irq),
    .cfg_we_i    (cfg_we),
    .cfg_re_i    (cfg_re),
    .cfg_addr_i  (cfg_addr),
    .cfg_wdata_i (cfg_wdata),
    .cfg_rdata_o (cfg_rdata),
    .threshold_i (threshold),
    .irq_valid_o (irq_valid),
    .irq_id_o    (irq_id),
    .irq_prio_o  (irq_prio),
    .irq_ready_i (irq_ready)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg_write(input logic [IdW-1:0] a, input logic [7:0] d);
    cfg_we = 1'b1; cfg_addr = a; cfg_wdata = d;
    tick();
    cfg_we = 1'b0;
  endtask

  task automatic cfg_read(input logic [IdW-1:0] a, output logic [7:0] d);
    cfg_re = 1'b1; cfg_addr = a;
    tick();
    cfg_re = 1'b0;
    d = cfg_rdata;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(); tick();
    checks++; if (irq_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %0b want 0", irq_valid); end
    checks++; if (irq_id !== 5'd0) begin errors++; $display("FAIL reset_id: got %0d want 0", irq_id); end
    checks++; if (irq_prio !== 3'd0) begin errors++; $display("FAIL reset_prio: got %0d want 0", irq_prio); end
    checks++; if (cfg_rdata !== 8'h00) begin errors++; $display("FAIL reset_rdata: got %02h want 00", cfg_rdata); end
    rst = 1'b0;
    cfg_read(5'd5, rd);
    checks++; if (rd !== 8'h00) begin errors++; $display("FAIL reset_cfg5: got %02h want 00", rd); end
  endtask

  task automatic test_edge_claim();
    threshold = 3'd0;
    cfg_write(5'd5, 8'h63);
    irq[5] = 1'b1;
    tick();
    irq[5] = 1'b0;
    checks++; if (irq_valid !== 1'b0) begin errors++; $display("FAIL edge_lat1_valid: got %0b want 0", irq_valid); end
    tick();
    checks++; if (irq_valid !== 1'b1 || irq_id !== 5'd5 || irq_prio !== 3'd3) begin
      errors++; $display("FAIL edge_offer: got v=%0b id=%0d p=%0d want v=1 id=5 p=3", irq_valid, irq_id, irq_prio);
    end
    cfg_read(5'd5, rd);
    checks++; if (rd !== (EdgeEn ? 8'h67 : 8'h61)) begin
      errors++; $display("FAIL edge_pending_rd: got %02h want %02h", rd, EdgeEn ? 8'h67 : 8'h61);
    end
    checks++; if (irq_valid !== 1'b1 || irq_id !== 5'd5) begin
      errors++; $display("FAIL edge_hold: got v=%0b id=%0d want v=1 id=5", irq_valid, irq_id);
    end
    irq_ready = 1'b1;
    tick();
    irq_ready = 1'b0;
    checks++; if (irq_valid !== 1'b0) begin errors++; $display("FAIL edge_gap: got %0b want 0", irq_valid); end
    cfg_read(5'd5, rd);
    checks++; if (rd !== (EdgeEn ? 8'h63 : 8'h61)) begin
      errors++; $display("FAIL edge_cleared_rd: got %02h want %02h", rd, EdgeEn ? 8'h63 : 8'h61);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (irq_valid !== 1'b0) begin errors++; $display("FAIL edge_no_reoffer[%0d]: got %0b want 0", i, irq_valid); end
    end
  endtask

  task automatic test_level_priority();
    cfg_write(5'd3, 8'h41);
    cfg_write(5'd7, 8'hC1);
    irq[3] = 1'b1; irq[7] = 1'b1;
    tick(); tick();
    checks++; if (irq_valid !== 1'b1 || irq_id !== 5'd7 || irq_prio !== 3'd6) begin
      errors++; $display("FAIL prio_first: got v=%0b id=%0d p=%0d want v=1 id=7 p=6", irq_valid, irq_id, irq_prio);
    end
    irq[7] = 1'b0; irq_ready = 1'b1;
    tick();
    irq_ready = 1'b0;
    checks++; if (irq_valid !== 1'b0) begin errors++; $display("FAIL prio_gap: got %0b want 0", irq_valid); end
    tick();
    checks++; if (irq_valid !== 1'b0) begin errors++; $display("FAIL prio_idle: got %0b want 0", irq_valid); end
    tick();
    checks++; if (irq_valid !== 1'b1 || irq_id !== 5'd3 || irq_prio !== 3'd2) begin
      errors++; $display("FAIL prio_second: got v=%0b id=%0d p=%0d want v=1 id=3 p=2", irq_valid, irq_id, irq_prio);
    end
    irq[3] = 1'b0; irq_ready = 1'b1;
    tick();
    irq_ready = 1'b0;
    tick(); tick(); tick();
    checks++; if (irq_valid !== 1'b0) begin errors++; $display("FAIL prio_drained: got %0b want 0", irq_valid); end
    cfg_write(5'd3, 8'h00);
    cfg_write(5'd7, 8'h00);
  endtask

  task automatic test_tie_threshold();
    cfg_write(5'd4, 8'hA1);
    cfg_write(5'd9, 8'hA1);
    threshold = 3'd5;
    irq[4] = 1'b1; irq[9] = 1'b1;
    tick(); tick(); tick();
    checks++; if (irq_valid !== 1'b0) begin errors++; $display("FAIL tie_blocked: got %0b want 0", irq_valid); end
    threshold = 3'd4;
    tick();
    checks++; if (irq_valid !== 1'b1 || irq_id !== 5'd4 || irq_prio !== 3'd5) begin
      errors++; $display("FAIL tie_offer: got v=%0b id=%0d p=%0d want v=1 id=4 p=5", irq_valid, irq_id, irq_prio);
    end
    irq[4] = 1'b0; irq[9] = 1'b0; irq_ready = 1'b1;
    tick();
    irq_ready = 1'b0;
    threshold = 3'd0;
    tick(); tick();
    checks++; if (irq_valid !== 1'b0) begin errors++; $display("FAIL tie_drained: got %0b want 0", irq_valid); end
    cfg_write(5'd4, 8'h00);
    cfg_write(5'd9, 8'h00);
  endtask

  task automatic test_hold_stable();
    cfg_write(5'd2, 8'h21);
    cfg_write(5'd8, 8'hE1);
    irq[2] = 1'b1;
    tick(); tick();
    checks++; if (irq_valid !== 1'b1 || irq_id !== 5'd2 || irq_prio !== 3'd1) begin
      errors++; $display("FAIL hold_first: got v=%0b id=%0d p=%0d want v=1 id=2 p=1", irq_valid, irq_id, irq_prio);
    end
    irq[8] = 1'b1;
    threshold = 3'd7;
    tick(); tick(); tick();
    checks++; if (irq_valid !== 1'b1 || irq_id !== 5'd2 || irq_prio !== 3'd1) begin
      errors++; $display("FAIL hold_stable: got v=%0b id=%0d p=%0d want v=1 id=2 p=1", irq_valid, irq_id, irq_prio);
    end
    threshold = 3'd0;
    irq[2] = 1'b0; irq_ready = 1'b1;
    tick();
    irq_ready = 1'b0;
    checks++; if (irq_valid !== 1'b0) begin errors++; $display("FAIL hold_gap: got %0b want 0", irq_valid); end
    tick(); tick();
    checks++; if (irq_valid !== 1'b1 || irq_id !== 5'd8 || irq_prio !== 3'd7) begin
      errors++; $display("FAIL hold_next: got v=%0b id=%0d p=%0d want v=1 id=8 p=7", irq_valid, irq_id, irq_prio);
    end
    irq[8] = 1'b0; irq_ready = 1'b1;
    tick();
    irq_ready = 1'b0;
    tick(); tick();
    cfg_write(5'd2, 8'h00);
    cfg_write(5'd8, 8'h00);
  endtask

`ifdef ZEROHETI_IRQ_EDGE_EN
  task automatic test_edge_same_cycle();
    cfg_write(5'd6, 8'h83);
    irq[6] = 1'b1;
    tick();
    irq[6] = 1'b0;
    tick();
    checks++; if (irq_valid !== 1'b1 || irq_id !== 5'd6) begin
      errors++; $display("FAIL same_first: got v=%0b id=%0d want v=1 id=6", irq_valid, irq_id);
    end
    irq[6] = 1'b1; irq_ready = 1'b1;
    tick();
    irq[6] = 1'b0; irq_ready = 1'b0;
    checks++; if (irq_valid !== 1'b0) begin errors++; $display("FAIL same_gap: got %0b want 0", irq_valid); end
    tick(); tick();
    checks++; if (irq_valid !== 1'b1 || irq_id !== 5'd6 || irq_prio !== 3'd4) begin
      errors++; $display("FAIL same_reoffer: got v=%0b id=%0d p=%0d want v=1 id=6 p=4", irq_valid, irq_id, irq_prio);
    end
    irq_ready = 1'b1;
    tick();
    irq_ready = 1'b0;
    tick(); tick();
    checks++; if (irq_valid !== 1'b0) begin errors++; $display("FAIL same_cleared: got %0b want 0", irq_valid); end
    irq[6] = 1'b1;
    cfg_write(5'd6, 8'h82);
    irq[6] = 1'b0;
    cfg_read(5'd6, rd);
    checks++; if (rd !== 8'h86) begin errors++; $display("FAIL same_wr_edge: got %02h want 86", rd); end
    cfg_write(5'd6, 8'h82);
    cfg_read(5'd6, rd);
    checks++; if (rd !== 8'h82) begin errors++; $display("FAIL same_wr_clear: got %02h want 82", rd); end
    cfg_write(5'd6, 8'h00);
  endtask
`endif

  task automatic test_level_rearm();
    cfg_write(5'd10, 8'h83);
    cfg_read(5'd10, rd);
    checks++; if (rd !== (EdgeEn ? 8'h83 : 8'h81)) begin
      errors++; $display("FAIL trig_readback: got %02h want %02h", rd, EdgeEn ? 8'h83 : 8'h81);
    end
    cfg_write(5'd10, 8'h00);
    cfg_write(5'd11, 8'h24);
    cfg_read(5'd11, rd);
    checks++; if (rd !== 8'h20) begin errors++; $display("FAIL level_ip_ignored: got %02h want 20", rd); end
    cfg_write(5'd12, 8'h41);
    irq[12] = 1'b1;
    tick(); tick();
    checks++; if (irq_valid !== 1'b1 || irq_id !== 5'd12 || irq_prio !== 3'd2) begin
      errors++; $display("FAIL rearm_first: got v=%0b id=%0d p=%0d want v=1 id=12 p=2", irq_valid, irq_id, irq_prio);
    end
    irq_ready = 1'b1;
    tick();
    irq_ready = 1'b0;
    checks++; if (irq_valid !== 1'b0) begin errors++; $display("FAIL rearm_gap: got %0b want 0", irq_valid); end
    tick(); tick();
    checks++; if (irq_valid !== 1'b1 || irq_id !== 5'd12) begin
      errors++; $display("FAIL rearm_again: got v=%0b id=%0d want v=1 id=12", irq_valid, irq_id);
    end
    irq[12] = 1'b0; irq_ready = 1'b1;
    tick();
    irq_ready = 1'b0;
    tick(); tick();
  endtask

  task automatic test_reset_during_offer();
    cfg_write(5'd7, 8'hC1);
    irq[7] = 1'b1;
    tick(); tick();
    checks++; if (irq_valid !== 1'b1 || irq_id !== 5'd7) begin
      errors++; $display("FAIL rst_pre_offer: got v=%0b id=%0d want v=1 id=7", irq_valid, irq_id);
    end
    rst = 1'b1;
    tick();
    checks++; if (irq_valid !== 1'b0 || irq_id !== 5'd0 || irq_prio !== 3'd0) begin
      errors++; $display("FAIL rst_offer_drop: got v=%0b id=%0d p=%0d want v=0 id=0 p=0", irq_valid, irq_id, irq_prio);
    end
    rst = 1'b0;
    irq = '0;
    cfg_read(5'd7, rd);
    checks++; if (rd !== 8'h00) begin errors++; $display("FAIL rst_cfg7: got %02h want 00", rd); end
    cfg_read(5'd12, rd);
    checks++; if (rd !== 8'h00) begin errors++; $display("FAIL rst_cfg12: got %02h want 00", rd); end
    tick(); tick();
    checks++; if (irq_valid !== 1'b0) begin errors++; $display("FAIL rst_quiet: got %0b want 0", irq_valid); end
  endtask

  initial begin
    test_reset();
    test_edge_claim();
    test_level_priority();
    test_tie_threshold();
    test_hold_stable();
`ifdef ZEROHETI_IRQ_EDGE_EN
    test_edge_same_cycle();
`endif
    test_level_rearm();
    test_reset_during_offer();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
